// File: rtl/aibio_dll_code_updn_cnt.sv
// DLL delay-code up/down counter: filters phase-detector votes, steps the code
// with saturation, supports direct load and flags lock after direction reversals.
module aibio_dll_code_updn_cnt #(
  parameter int WIDTH    = 4,
  parameter int FILT     = 4,
  parameter int LOCK_REV = 3,
  parameter int MIN_CODE = 0,
  parameter int MAX_CODE = 15,
  parameter int RST_CODE = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             vddcq,
  input  logic             vss,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_code,
  input  logic             i_up,
  input  logic             i_dn,
  input  logic [1:0]       i_step,
  output logic [WIDTH-1:0] o_code,
  output logic             o_upd,
  output logic             o_at_min,
  output logic             o_at_max,
  output logic             o_lock
);

  localparam int CW = WIDTH + 4;  // headroom so code+8 never overflows
  localparam int AW = 5;
  localparam int RW = 4;

  localparam logic [CW-1:0]        MINC  = CW'(MIN_CODE);
  localparam logic [CW-1:0]        MAXC  = CW'(MAX_CODE);
  localparam logic signed [AW-1:0] A_ONE = AW'(1);
  localparam logic signed [AW-1:0] A_POS = AW'(FILT);
  localparam logic signed [AW-1:0] A_NEG = AW'(-FILT);
  localparam logic [RW-1:0]        REV_N = RW'(LOCK_REV);

  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_DN   = 2'd2;

  logic [WIDTH-1:0]        code_q, code_d;
  logic signed [AW-1:0]    acc_q, acc_d, acc_nx;
  logic [1:0]              dir_q, dir_d, dir_new;
  logic [RW-1:0]           rev_q, rev_d;
  logic                    upd_q, upd_d;
  logic                    lock_q, lock_d;

  logic                    vote_up, vote_dn, fire, at_lim, applied;
  logic                    at_min, at_max;
  logic [CW-1:0]           code_ext, stepv, up_t, up_c, dn_c, tgt, ld_ext, ld_c;

  logic unused_pwr;
  assign unused_pwr = vddcq ^ vss;

  assign at_min = (code_q == WIDTH'(MIN_CODE));
  assign at_max = (code_q == WIDTH'(MAX_CODE));

  always_comb begin
    vote_up = i_up & ~i_dn;
    vote_dn = i_dn & ~i_up;

    // an opposite vote restarts the filter from +/-1 rather than decaying
    acc_nx = acc_q;
    if (vote_up)      acc_nx = (acc_q < 0) ? A_ONE : acc_q + A_ONE;
    else if (vote_dn) acc_nx = (acc_q > 0) ? -A_ONE : acc_q - A_ONE;
    fire = (vote_up && acc_nx == A_POS) || (vote_dn && acc_nx == A_NEG);

    code_ext = CW'(code_q);
    stepv    = CW'(1) << i_step;
    up_t     = code_ext + stepv;
    up_c     = (up_t > MAXC) ? MAXC : up_t;
    dn_c     = (code_ext < MINC + stepv) ? MINC : code_ext - stepv;
    tgt      = vote_up ? up_c : dn_c;
    at_lim   = vote_up ? at_max : at_min;
    applied  = fire && !at_lim;
    dir_new  = vote_up ? DIR_UP : DIR_DN;

    ld_ext = CW'(i_load_code);
    ld_c   = (ld_ext < MINC) ? MINC : ((ld_ext > MAXC) ? MAXC : ld_ext);
  end

  always_comb begin
    code_d = code_q;
    acc_d  = acc_q;
    dir_d  = dir_q;
    rev_d  = rev_q;
    lock_d = lock_q;
    upd_d  = 1'b0;
    if (i_load) begin
      code_d = WIDTH'(ld_c);
      upd_d  = (WIDTH'(ld_c) != code_q);
      acc_d  = '0;
      dir_d  = DIR_NONE;
      rev_d  = '0;
      lock_d = 1'b0;
    end else if (i_en) begin
      acc_d = fire ? '0 : acc_nx;
      if (applied) begin
        code_d = WIDTH'(tgt);
        upd_d  = 1'b1;
        if (dir_q != DIR_NONE && dir_q != dir_new && rev_q != REV_N)
          rev_d = rev_q + RW'(1);
        dir_d  = dir_new;
        lock_d = lock_q | (rev_d == REV_N);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      code_q <= WIDTH'(RST_CODE);
      acc_q  <= '0;
      dir_q  <= DIR_NONE;
      rev_q  <= '0;
      upd_q  <= 1'b0;
      lock_q <= 1'b0;
    end else begin
      code_q <= code_d;
      acc_q  <= acc_d;
      dir_q  <= dir_d;
      rev_q  <= rev_d;
      upd_q  <= upd_d;
      lock_q <= lock_d;
    end
  end

  assign o_code   = code_q;
  assign o_upd    = upd_q;
  assign o_at_min = at_min;
  assign o_at_max = at_max;
  assign o_lock   = lock_q;

endmodule
